// File: rtl/tmr_vote_controller.sv
// tmr_vote_controller
//   Bitwise 2-of-3 majority voter for three redundant WIDTH-bit producers.
//   Collects one word per channel (valid/ready), votes, then presents the
//   result on a valid/ready output. Tracks consecutive per-channel
//   disagreements and retires a channel as faulty after FAULT_LIMIT of them,
//   degrading to 2- or 1-channel voting.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid[2:0]  per-channel valid (bit0=a, bit1=b, bit2=c)
//   in_ready[2:0]  per-channel ready
//   in_a/b/c       channel data
//   out_valid      voted word available; out_ready accepts it
//   out_data       voted word; out_mismatch flags disagreement among present words
//   out_drop       1-cycle pulse when a round is discarded at timeout
//   clear_fault    clears fault flags and disagreement counters
//   fault[2:0]     sticky per-channel faulty flags
module tmr_vote_controller #(
  parameter int WIDTH       = 8,
  parameter int TIMEOUT     = 15,
  parameter int FAULT_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       in_valid,
  output logic [2:0]       in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mismatch,
  output logic             out_drop,
  input  logic             clear_fault,
  output logic [2:0]       fault
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(FAULT_LIMIT + 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_VOTE,
    S_OUTPUT
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cap_q, cap_d;
  logic [WIDTH-1:0] word_q [3];
  logic [WIDTH-1:0] word_d [3];
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    cnt_q [3];
  logic [CW-1:0]    cnt_d [3];
  logic [2:0]       fault_q, fault_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             omm_q, omm_d;
  logic             drop_q, drop_d;

  logic [WIDTH-1:0] in_word [3];
  logic [2:0]       fire;
  logic [2:0]       cap_next;
  logic [WIDTH-1:0] maj, and_all, vote_res;
  logic [2:0]       neq;
  logic             vote_mm;

  assign in_word[0] = in_a;
  assign in_word[1] = in_b;
  assign in_word[2] = in_c;

  assign in_ready = (state_q == S_COLLECT) ? (~cap_q & ~fault_q) : '0;
  assign fire     = in_valid & in_ready;
  assign cap_next = cap_q | fire;

  // With fewer than three words, the AND of the present words equals the
  // word itself when they agree, so one expression covers N=1 and N=2.
  assign maj      = (word_q[0] & word_q[1]) | (word_q[0] & word_q[2]) | (word_q[1] & word_q[2]);
  assign and_all  = (cap_q[0] ? word_q[0] : '1) & (cap_q[1] ? word_q[1] : '1) &
                    (cap_q[2] ? word_q[2] : '1);
  assign vote_res = (cap_q == 3'b111) ? maj : and_all;
  assign neq      = {word_q[2] != vote_res, word_q[1] != vote_res, word_q[0] != vote_res};
  assign vote_mm  = |(cap_q & neq);

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    timer_d = timer_q;
    fault_d = fault_q;
    odata_d = odata_q;
    omm_d   = omm_q;
    drop_d  = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      word_d[i] = word_q[i];
      cnt_d[i]  = cnt_q[i];
    end

    unique case (state_q)
      S_COLLECT: begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (fire[i]) word_d[i] = in_word[i];
        end
        cap_d = cap_next;
        if (timer_q != '0 || fire != '0) timer_d = timer_q + 1'b1;
        // All-faulty leaves the required set empty; idle rather than vote.
        if (fault_q != 3'b111 && (cap_next & ~fault_q) == ~fault_q) begin
          state_d = S_VOTE;
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT)) begin
          timer_d = '0;
          if ($countones(cap_next) >= 2) begin
            state_d = S_VOTE;
          end else begin
            drop_d = 1'b1;
            cap_d  = '0;
          end
        end
      end

      S_VOTE: begin
        odata_d = vote_res;
        omm_d   = vote_mm;
        for (int unsigned i = 0; i < 3; i++) begin
          if (!fault_q[i]) begin
            if (cap_q == 3'b111) begin
              if (neq[i]) begin
                cnt_d[i] = (cnt_q[i] == CW'(FAULT_LIMIT)) ? cnt_q[i] : cnt_q[i] + 1'b1;
              end else begin
                cnt_d[i] = '0;
              end
            end else if (!cap_q[i]) begin
              cnt_d[i] = (cnt_q[i] == CW'(FAULT_LIMIT)) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end
            fault_d[i] = (cnt_d[i] == CW'(FAULT_LIMIT));
          end
        end
        state_d = S_OUTPUT;
      end

      S_OUTPUT: begin
        if (out_ready) begin
          state_d = S_COLLECT;
          cap_d   = '0;
          timer_d = '0;
        end
      end

      default: state_d = S_COLLECT;
    endcase

    if (clear_fault) begin
      fault_d = '0;
      for (int unsigned i = 0; i < 3; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COLLECT;
      cap_q   <= '0;
      timer_q <= '0;
      fault_q <= '0;
      odata_q <= '0;
      omm_q   <= 1'b0;
      drop_q  <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        word_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
      odata_q <= odata_d;
      omm_q   <= omm_d;
      drop_q  <= drop_d;
      for (int unsigned i = 0; i < 3; i++) begin
        word_q[i] <= word_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign out_valid    = (state_q == S_OUTPUT);
  assign out_data     = odata_q;
  assign out_mismatch = omm_q;
  assign out_drop     = drop_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_tmr_vote_controller.sv
// Directed bench for tmr_vote_controller with a round-level reference model
// and a per-cycle compare process.
module tb_tmr_vote_controller;
  localparam int W  = 8;
  localparam int TO = 15;
  localparam int FL = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   in_valid = '0;
  logic [2:0]   in_ready;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_mismatch;
  logic         out_drop;
  logic         clear_fault = 1'b0;
  logic [2:0]   fault;

  always #5 clk = ~clk;

  tmr_vote_controller #(.WIDTH(W), .TIMEOUT(TO), .FAULT_LIMIT(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mismatch(out_mismatch), .out_drop(out_drop),
    .clear_fault(clear_fault), .fault(fault)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Expected observable state, maintained by the stimulus and the model.
  logic [2:0]   exp_ready = 3'b111;
  bit           exp_valid = 1'b0;
  bit           exp_drop  = 1'b0;
  logic [W-1:0] exp_data  = '0;
  bit           exp_mm    = 1'b0;
  int           mcount [3] = '{0, 0, 0};
  logic [2:0]   mfault = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(in_ready),  32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_drop",  32'(out_drop),  32'(exp_drop));
      chk("fault",     32'(fault),     32'(mfault));
      if (exp_valid) begin
        chk("out_data",     32'(out_data),     32'(exp_data));
        chk("out_mismatch", 32'(out_mismatch), 32'(exp_mm));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-level model: what a vote over the present words must produce and
  // how the disagreement history of each live channel evolves.
  task automatic model_vote(input logic [2:0] pres, input logic [W-1:0] w0, w1, w2);
    logic [W-1:0] w [3];
    logic [W-1:0] p [$];
    logic [W-1:0] res;
    bit mm;
    int ones;
    w = '{w0, w1, w2};
    for (int i = 0; i < 3; i++) if (pres[i]) p.push_back(w[i]);
    res = '0;
    mm  = 1'b0;
    if (p.size() == 3) begin
      for (int b = 0; b < W; b++) begin
        ones = int'(w[0][b]) + int'(w[1][b]) + int'(w[2][b]);
        res[b] = (ones >= 2);
      end
      for (int i = 0; i < 3; i++) begin
        if (w[i] != res) mm = 1'b1;
        if (!mfault[i]) mcount[i] = (w[i] != res) ? ((mcount[i] < FL) ? mcount[i] + 1 : FL) : 0;
      end
    end else begin
      if (p.size() == 2) begin
        if (p[0] == p[1]) res = p[0];
        else begin
          res = p[0] & p[1];
          mm  = 1'b1;
        end
      end else begin
        res = p[0];
      end
      for (int i = 0; i < 3; i++)
        if (!mfault[i] && !pres[i]) mcount[i] = (mcount[i] < FL) ? mcount[i] + 1 : FL;
    end
    for (int i = 0; i < 3; i++) if (mcount[i] >= FL) mfault[i] = 1'b1;
    exp_data = res;
    exp_mm   = mm;
  endtask

  // One complete round: channels in vm offer their word in the first cycle.
  task automatic round(input logic [2:0] vm, input logic [W-1:0] a, b, c, input int hold);
    logic [2:0] req, pres;
    req  = ~mfault;
    pres = vm & req;
    in_a = a; in_b = b; in_c = c;
    in_valid = vm;
    tick();
    in_valid = '0;
    if (pres != req) begin
      exp_ready = req & ~pres;
      repeat (TO - 1) tick();
      tick();
      if ($countones(pres) < 2) begin
        exp_drop  = 1'b1;
        exp_ready = req;
        tick();
        exp_drop = 1'b0;
        return;
      end
    end
    exp_ready = '0;
    tick();
    model_vote(pres, a, b, c);
    exp_valid = 1'b1;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_valid = 1'b0;
    exp_ready = ~mfault;
  endtask

  task automatic do_clear();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    mfault = '0;
    mcount = '{0, 0, 0};
    exp_ready = 3'b111;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_out_mm",   32'(out_mismatch), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h7);

    // All agree
    round(3'b111, 8'h5A, 8'h5A, 8'h5A, 0);
    chk("t1_data", 32'(out_data), 32'h5A);
    chk("t1_mm",   32'(out_mismatch), 32'h0);

    // Outvote c three times -> c retired
    round(3'b111, 8'hF0, 8'hF0, 8'h0F, 0);
    chk("t2_data", 32'(out_data), 32'hF0);
    chk("t2_mm",   32'(out_mismatch), 32'h1);
    chk("t2_fault_after1", 32'(fault), 32'h0);
    round(3'b111, 8'hF0, 8'hF0, 8'h0F, 0);
    round(3'b111, 8'hF0, 8'hF0, 8'h0F, 0);
    chk("t2_fault", 32'(fault), 32'h4);
    chk("t2_ready", 32'(in_ready), 32'h3);
    do_clear();

    // Timeout with two words, then with one word (drop)
    round(3'b011, 8'h33, 8'h33, 8'h00, 0);
    chk("t3_data", 32'(out_data), 32'h33);
    chk("t3_mm",   32'(out_mismatch), 32'h0);
    round(3'b001, 8'h11, 8'h00, 8'h00, 0);
    chk("t3_drop_keeps_data", 32'(out_data), 32'h33);

    // c already has one miss; two more outvotes retire it, then degraded vote
    round(3'b111, 8'hF0, 8'hF0, 8'h0F, 0);
    chk("t4_fault_pre", 32'(fault), 32'h0);
    round(3'b111, 8'hF0, 8'hF0, 8'h0F, 0);
    chk("t4_fault", 32'(fault), 32'h4);
    round(3'b111, 8'hAA, 8'hA0, 8'h55, 0);
    chk("t4_data", 32'(out_data), 32'hA0);
    chk("t4_mm",   32'(out_mismatch), 32'h1);
    do_clear();
    chk("t4_clear_fault", 32'(fault), 32'h0);
    chk("t4_clear_ready", 32'(in_ready), 32'h7);

    // Backpressure, then a following round
    round(3'b111, 8'hC3, 8'hC3, 8'hC3, 10);
    chk("t5_data", 32'(out_data), 32'hC3);
    round(3'b111, 8'h12, 8'h34, 8'h12, 0);
    chk("t5_data2", 32'(out_data), 32'h12);
    chk("t5_mm2",   32'(out_mismatch), 32'h1);

    // Reset mid-round after capturing only a
    in_a = 8'hEE;
    in_valid = 3'b001;
    tick();
    in_valid = '0;
    exp_ready = 3'b110;
    tick();
    chk_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mfault = '0;
    mcount = '{0, 0, 0};
    exp_ready = 3'b111;
    exp_valid = 1'b0;
    exp_drop  = 1'b0;
    chk_en = 1'b1;
    chk("t6_rst_data",  32'(out_data), 32'h0);
    chk("t6_rst_ready", 32'(in_ready), 32'h7);
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    round(3'b111, 8'h77, 8'h77, 8'h77, 0);
    chk("t6_data", 32'(out_data), 32'h77);
    chk("t6_mm",   32'(out_mismatch), 32'h0);

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
